// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [31:0] TIMEOUT_RDATA_DEF = 32'hDEADBEEF;
  localparam int unsigned CNT_W             = 8;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-input round-robin pick with the last-grant history register.
module mem_arb_rr (
  input  logic       clock,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       load,
  output logic       pick,
  output logic       last_grant
);

  // Lone requester always wins; on contention the master not granted last wins.
  always_comb begin
    pick = 1'b0;
    unique case (req)
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last_grant;
      default: pick = 1'b0;
    endcase
  end

  // History resets to m1 so m0 wins the first contention.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      last_grant <= 1'b1;
    end else if (load) begin
      last_grant <= pick;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master to one-memory arbiter with round-robin grant and a BUSY timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT       = 255,
  parameter logic [31:0] TIMEOUT_RDATA = TIMEOUT_RDATA_DEF
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             m0_valid,
  output logic             m0_ready,
  input  logic [31:0]      m0_addr,
  input  logic [31:0]      m0_wdata,
  input  logic [3:0]       m0_wstrb,
  output logic [31:0]      m0_rdata,
  input  logic             m1_valid,
  output logic             m1_ready,
  input  logic [31:0]      m1_addr,
  input  logic [31:0]      m1_wdata,
  input  logic [3:0]       m1_wstrb,
  output logic [31:0]      m1_rdata,
  output logic             s_valid,
  input  logic             s_ready,
  output logic [31:0]      s_addr,
  output logic [31:0]      s_wdata,
  output logic [3:0]       s_wstrb,
  input  logic [31:0]      s_rdata,
  output logic             timeout_err,
  output logic [CNT_W-1:0] err_count
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             granted;
  logic             pick;
  logic             load;
  logic             timeout_hit;
  logic             done;
  logic [31:0]      resp;

  assign load = (state == IDLE) && (m0_valid || m1_valid);

  // The history register doubles as the record of the master owning BUSY.
  mem_arb_rr u_rr (
    .clock      (clock),
    .resetn     (resetn),
    .req        ({m1_valid, m0_valid}),
    .load       (load),
    .pick       (pick),
    .last_grant (granted)
  );

  // Completion/abort decode and response steering; s_ready wins over timeout.
  always_comb begin
    timeout_hit = 1'b0;
    done        = 1'b0;
    if (state == BUSY) begin
      timeout_hit = !s_ready && (cnt == CNT_W'(TIMEOUT - 1));
      done        = s_ready || timeout_hit;
    end
    resp        = timeout_hit ? TIMEOUT_RDATA : s_rdata;
    m0_ready    = done && !granted;
    m1_ready    = done && granted;
    m0_rdata    = resp;
    m1_rdata    = resp;
    timeout_err = timeout_hit;
    s_valid     = (state == BUSY);
  end

  // FSM, request latch, timeout counter and saturating abort counter.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_wstrb   <= '0;
      cnt       <= '0;
      err_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load) begin
            state <= BUSY;
            cnt   <= '0;
            if (pick) begin
              s_addr  <= m1_addr;
              s_wdata <= m1_wdata;
              s_wstrb <= m1_wstrb;
            end else begin
              s_addr  <= m0_addr;
              s_wdata <= m0_wdata;
              s_wstrb <= m0_wstrb;
            end
          end
        end
        BUSY: begin
          if (done) begin
            state <= IDLE;
            if (timeout_hit && (err_count != '1)) begin
              err_count <= err_count + CNT_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
